bit_serial_alu_ctrl: RTL and testbench

//  Sequencer that time-shares one 1-bit ALU slice (AND/OR/ADD/SUB) across a WIDTH-bit operation.

---
 rtl/bit_serial_alu_ctrl_pkg.sv | 25 ++
 rtl/bit_serial_alu_ctrl_if.sv | 34 +++
 rtl/bit_serial_alu_ctrl_slice.sv | 51 +++++
 rtl/bit_serial_alu_ctrl.sv | 119 +++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : bit_serial_alu_ctrl_pkg
// Opcodes, FSM state encoding and helpers for the bit-serial ALU sequencer.
// Rev    : 1.0
// ============================================================================
package bit_serial_alu_ctrl_pkg;

  localparam logic [1:0] c_ALU_AND = 2'b00;
  localparam logic [1:0] c_ALU_OR  = 2'b01;
  localparam logic [1:0] c_ALU_ADD = 2'b10;
  localparam logic [1:0] c_ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_sub(input logic [1:0] op);
    return (op == c_ALU_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serial_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : bit_serial_alu_ctrl_if
// Start/busy/done request bus between register file side and the sequencer.
// Rev    : 1.0
// ============================================================================
interface bit_serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  import bit_serial_alu_ctrl_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero
  );

endinterface
`default_nettype wire

// File: rtl/bit_serial_alu_ctrl_slice.sv
`default_nettype none
// ============================================================================
// Module : alu_slice_1bit
// Combinational 1-bit AND/OR/ADD slice; SUB is ADD with inverted b and cin=1.
// Rev    : 1.0
// ============================================================================
module alu_slice_1bit (
  output wire       out_o,
  output wire       cout_o,
  input  wire       a_i,
  input  wire       b_i,
  input  wire       cin_i,
  input  wire [1:0] op_i
);

  wire w_and;
  wire w_or;
  wire w_prop;
  wire w_sum;
  wire w_prop_cin;
  wire w_maj;
  wire w_n_op0;
  wire w_sel_and;
  wire w_sel_or;
  wire w_logic;
  wire w_n_op1;
  wire w_sel_logic;
  wire w_sel_sum;

  and g_and      (w_and, a_i, b_i);
  or  g_or       (w_or, a_i, b_i);
  xor g_prop     (w_prop, a_i, b_i);
  xor g_sum      (w_sum, w_prop, cin_i);
  and g_prop_cin (w_prop_cin, w_prop, cin_i);
  or  g_maj      (w_maj, w_and, w_prop_cin);

  // op[0] picks OR over AND for logic ops; op[1] picks the adder path
  not g_n_op0    (w_n_op0, op_i[0]);
  and g_sel_and  (w_sel_and, w_and, w_n_op0);
  and g_sel_or   (w_sel_or, w_or, op_i[0]);
  or  g_logic    (w_logic, w_sel_and, w_sel_or);

  not g_n_op1    (w_n_op1, op_i[1]);
  and g_sel_log  (w_sel_logic, w_logic, w_n_op1);
  and g_sel_sum  (w_sel_sum, w_sum, op_i[1]);
  or  g_out      (out_o, w_sel_logic, w_sel_sum);

  and g_cout     (cout_o, w_maj, op_i[1]);

endmodule
`default_nettype wire

// File: rtl/bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bit_serial_alu_ctrl
// Sequences one 1-bit ALU slice over a WIDTH-bit operation, LSB first.
// Rev    : 1.0
// ============================================================================
module bit_serial_alu_ctrl
  import bit_serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  bit_serial_alu_ctrl_if.slave     bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [1:0]       op_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             w_slice_b;
  logic             w_slice_out;
  logic             w_slice_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_slice_b  = b_sh_q[0] ^ is_sub(op_q);
  assign w_last     = (cnt_q == CNT_W'(WIDTH - 1));
  assign w_res_next = {w_slice_out, res_q[WIDTH-1:1]};

  alu_slice_1bit u_slice (
    .out_o  (w_slice_out),
    .cout_o (w_slice_cout),
    .a_i    (a_sh_q[0]),
    .b_i    (w_slice_b),
    .cin_i  (carry_q),
    .op_i   (op_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      op_q    <= c_ALU_AND;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            op_q    <= bus.op;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= is_sub(bus.op);
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          res_q   <= w_res_next;
          carry_q <= w_slice_cout;
          if (w_last) begin
            // carry_q still holds the carry into the MSB on this cycle
            cout_q  <= w_slice_cout;
            ovf_q   <= carry_q ^ w_slice_cout;
            zero_q  <= ~|w_res_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_bit_serial_alu_ctrl
// Scoreboard bench for the bit-serial ALU sequencer (WIDTH=8).
// Rev    : 1.0
// ============================================================================
module tb_bit_serial_alu_ctrl;
  import bit_serial_alu_ctrl_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   t_start = 0;
  bit   overlap = 1'b0;
  exp_t sb[$];

  bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.busy === 1'b1 && bus.done === 1'b1) overlap <= 1'b1;

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t     e;
    logic [W:0] s;
    e = '0;
    case (op)
      c_ALU_AND: e.res = a & b;
      c_ALU_OR:  e.res = a | b;
      c_ALU_ADD: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      default: begin
        s     = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(op, a, b));
    t_start = cyc;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
               bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b res=%h, want all 0", bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_arith;
    logic [1:0]   ops [4] = '{c_ALU_ADD, c_ALU_SUB, c_ALU_SUB, c_ALU_ADD};
    logic [W-1:0] as  [4] = '{8'h7F, 8'h05, 8'h00, 8'hC0};
    logic [W-1:0] bs  [4] = '{8'h01, 8'h05, 8'h01, 8'h80};
    exp_t e;
    bit   ok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0);
      wait_done(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || (cyc - t_start) != W + 1) begin
        miscompares++;
        $display("FAIL arith_latency[%0d]: done=%0b after %0d cycles, want %0d", i, ok, cyc - t_start, W + 1);
      end
      vectors++;
      if ({bus.result, bus.carry_out, bus.overflow, bus.zero} !== e) begin
        miscompares++;
        $display("FAIL arith_result[%0d]: got res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b", i,
                 bus.result, bus.carry_out, bus.overflow, bus.zero, e.res, e.c, e.v, e.z);
      end
      repeat (2) begin @(posedge clk); #1; end
      vectors++;
      if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero} !== {2'b00, e}) begin
        miscompares++;
        $display("FAIL arith_hold[%0d]: busy=%b done=%b res=%h c=%b v=%b z=%b, want 0 0 %h %b %b %b", i,
                 bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero, e.res, e.c, e.v, e.z);
      end
    end
  endtask

  task automatic test_logic;
    logic [1:0]   ops [3] = '{c_ALU_OR, c_ALU_AND, c_ALU_AND};
    logic [W-1:0] as  [3] = '{8'hA0, 8'hF0, 8'h00};
    logic [W-1:0] bs  [3] = '{8'h0F, 8'h3C, 8'hFF};
    exp_t e;
    bit   ok;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0);
      wait_done(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || {bus.result, bus.carry_out, bus.overflow, bus.zero} !== e) begin
        miscompares++;
        $display("FAIL logic_result[%0d]: done=%0b res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b", i, ok,
                 bus.result, bus.carry_out, bus.overflow, bus.zero, e.res, e.c, e.v, e.z);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    bit   ok;
    issue(c_ALU_ADD, 8'h10, 8'h20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = c_ALU_AND;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_busy: busy=%b, want 1", bus.busy);
    end
    wait_done(ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || (cyc - t_start) != W + 1 || {bus.result, bus.carry_out, bus.overflow, bus.zero} !== e) begin
      miscompares++;
      $display("FAIL ignore_result: done=%0b at +%0d res=%h, want at +%0d res=%h", ok, cyc - t_start,
               bus.result, W + 1, e.res);
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    bit   ok;
    bit   seen_done = 1'b0;
    issue(c_ALU_ADD, 8'h55, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    vectors++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
               bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero);
    end
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_done: activity seen=%b, want 0", seen_done);
    end
    issue(c_ALU_ADD, 8'hFF, 8'h01, 1'b0);
    wait_done(ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || {bus.result, bus.carry_out, bus.overflow, bus.zero} !== e) begin
      miscompares++;
      $display("FAIL midrun_after: done=%0b res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b", ok,
               bus.result, bus.carry_out, bus.overflow, bus.zero, e.res, e.c, e.v, e.z);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]   ops [5] = '{c_ALU_ADD, c_ALU_SUB, c_ALU_ADD, c_ALU_SUB, c_ALU_AND};
    logic [W-1:0] as  [5] = '{8'h12, 8'h34, 8'h80, 8'h00, 8'hFF};
    logic [W-1:0] bs  [5] = '{8'h34, 8'h12, 8'h80, 8'h80, 8'hAA};
    exp_t e;
    bit   ok;
    issue(ops[0], as[0], bs[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_done(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || (cyc - t_start) != W + 1 || {bus.result, bus.carry_out, bus.overflow, bus.zero} !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d]: done=%0b at +%0d res=%h c=%b v=%b z=%b, want at +%0d res=%h c=%b v=%b z=%b",
                 i, ok, cyc - t_start, bus.result, bus.carry_out, bus.overflow, bus.zero,
                 W + 1, e.res, e.c, e.v, e.z);
      end
      if (i < 4) issue(ops[i+1], as[i+1], bs[i+1], 1'b1);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    vectors++;
    if (overlap !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_done_overlap: seen=%b, want 0", overlap);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = c_ALU_AND;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_arith();
    test_logic();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
